// File: rtl/avmm_pkg.sv
// Shared Avalon-MM widths, defaults and the read-pipeline entry type for the SDR responder.
package avmm_pkg;

  localparam int unsigned AVMM_DATA_W = 16;
  localparam int unsigned AVMM_ADDR_W = 32;
  localparam int unsigned AVMM_BE_W   = 2;

  localparam logic [AVMM_DATA_W-1:0] ERR_DATA_DEFAULT = 16'hDEAD;

  typedef struct packed {
    logic                   valid;
    logic                   oob;
    logic [AVMM_DATA_W-1:0] data;
  } rd_entry_t;

  // Merge write data into a stored halfword, one byte lane per byteenable bit.
  function automatic logic [AVMM_DATA_W-1:0] be_merge(input logic [AVMM_DATA_W-1:0] old_data,
                                                      input logic [AVMM_DATA_W-1:0] new_data,
                                                      input logic [AVMM_BE_W-1:0]   be);
    logic [AVMM_DATA_W-1:0] res;
    res = old_data;
    if (be[0]) res[7:0] = new_data[7:0];
    if (be[1]) res[15:8] = new_data[15:8];
    return res;
  endfunction

endpackage

// File: rtl/avmm_sdr_responder_if.sv
// Avalon-MM slave bus bundle (s0) with master and slave views.
interface avmm_sdr_responder_if;
  import avmm_pkg::*;

  logic                   avs_s0_read;
  logic                   avs_s0_write;
  logic [AVMM_ADDR_W-1:0] avs_s0_address;
  logic [AVMM_DATA_W-1:0] avs_s0_writedata;
  logic [AVMM_BE_W-1:0]   avs_s0_byteenable;
  logic [AVMM_DATA_W-1:0] avs_s0_readdata;
  logic                   avs_s0_readdatavalid;
  logic                   avs_s0_waitrequest;

  modport master (
    output avs_s0_read,
    output avs_s0_write,
    output avs_s0_address,
    output avs_s0_writedata,
    output avs_s0_byteenable,
    input  avs_s0_readdata,
    input  avs_s0_readdatavalid,
    input  avs_s0_waitrequest
  );

  modport slave (
    input  avs_s0_read,
    input  avs_s0_write,
    input  avs_s0_address,
    input  avs_s0_writedata,
    input  avs_s0_byteenable,
    output avs_s0_readdata,
    output avs_s0_readdatavalid,
    output avs_s0_waitrequest
  );

endinterface

// File: rtl/avmm_read_pipe.sv
// Fixed-latency read return pipeline with outstanding-read counter and full flag.
module avmm_read_pipe
  import avmm_pkg::*;
#(
  parameter int unsigned            READ_LATENCY = 2,
  parameter int unsigned            MAX_PENDING  = 4,
  parameter logic [AVMM_DATA_W-1:0] ERR_DATA     = ERR_DATA_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   oob_i,
  input  logic [AVMM_DATA_W-1:0] data_i,
  output logic                   rvalid_o,
  output logic [AVMM_DATA_W-1:0] rdata_o,
  output logic                   full_o
);

  localparam int unsigned CntW = $clog2(MAX_PENDING + 1);

  rd_entry_t       pipe_q [READ_LATENCY];
  rd_entry_t       pipe_d [READ_LATENCY];
  logic [CntW-1:0] pending_q, pending_d;
  logic            retire;

  assign retire = pipe_q[READ_LATENCY-1].valid;

  always_comb begin
    pipe_d[0] = '0;
    if (push_i) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].oob   = oob_i;
      pipe_d[0].data  = data_i;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Accept and retire in one cycle cancel out.
  assign pending_d = pending_q + CntW'(push_i) - CntW'(retire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      pipe_q    <= pipe_d;
      pending_q <= pending_d;
    end
  end

  assign rvalid_o = pipe_q[READ_LATENCY-1].valid;
  assign rdata_o  = pipe_q[READ_LATENCY-1].oob ? ERR_DATA : pipe_q[READ_LATENCY-1].data;
  assign full_o   = (pending_q == CntW'(MAX_PENDING));

endmodule

// File: rtl/avmm_sdr_responder.sv
// Avalon-MM 16-bit slave over an on-chip halfword array, with a host backdoor port.
// Optional build macro AVS_STALL_INJECT_EN adds pseudo-random waitrequest stalls.
module avmm_sdr_responder
  import avmm_pkg::*;
#(
  parameter int unsigned            DEPTH        = 4096,
  parameter int unsigned            READ_LATENCY = 2,
  parameter int unsigned            MAX_PENDING  = 4,
  parameter logic [AVMM_DATA_W-1:0] ERR_DATA     = ERR_DATA_DEFAULT,
  localparam int unsigned           HostAw       = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  avmm_sdr_responder_if.slave    avs,
  input  logic                   host_en,
  input  logic                   host_we,
  input  logic [HostAw-1:0]      host_addr,
  input  logic [AVMM_DATA_W-1:0] host_wdata,
  output logic [AVMM_DATA_W-1:0] host_rdata,
  output logic                   o_err
);

  localparam logic [AVMM_ADDR_W-2:0] DepthIdx = DEPTH[AVMM_ADDR_W-2:0];

  logic [AVMM_DATA_W-1:0] mem_q [DEPTH];

  logic [AVMM_ADDR_W-2:0] slv_idx;
  logic [HostAw-1:0]      mem_idx;
  logic                   slv_oob;
  logic                   host_ok;
  logic                   rd_full;
  logic                   stall_inj;
  logic                   waitreq;
  logic                   rd_acc, wr_req, wr_acc;
  logic [AVMM_DATA_W-1:0] rd_data;
  logic [AVMM_DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic                   err_q, err_d;
  logic                   unused_addr0;

  assign unused_addr0 = avs.avs_s0_address[0];

  assign slv_idx = avs.avs_s0_address[AVMM_ADDR_W-1:1];
  assign mem_idx = slv_idx[HostAw-1:0];
  assign slv_oob = (slv_idx >= DepthIdx);
  assign host_ok = (32'(host_addr) < DEPTH);

`ifdef AVS_STALL_INJECT_EN
  logic [3:0] lfsr_q, lfsr_d;

  assign lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  assign stall_inj = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lfsr_q <= 4'b1001;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign stall_inj = 1'b0;
`endif

  // Host owns the array whenever host_en is high; the slave is held off.
  assign waitreq = host_en | rd_full | stall_inj;

  assign rd_acc  = avs.avs_s0_read & ~waitreq;
  assign wr_req  = avs.avs_s0_write & ~waitreq;
  assign wr_acc  = wr_req & ~avs.avs_s0_read & ~slv_oob;
  assign rd_data = slv_oob ? '0 : mem_q[mem_idx];

  always_ff @(posedge i_clk) begin
    if (host_en && host_we && host_ok) begin
      mem_q[host_addr] <= host_wdata;
    end else if (wr_acc) begin
      mem_q[mem_idx] <= be_merge(mem_q[mem_idx], avs.avs_s0_writedata, avs.avs_s0_byteenable);
    end
  end

  always_comb begin
    host_rdata_d = host_rdata_q;
    if (host_en && !host_we) begin
      host_rdata_d = host_ok ? mem_q[host_addr] : ERR_DATA;
    end
    err_d = err_q | (rd_acc & slv_oob) | (wr_req & slv_oob) | (wr_req & avs.avs_s0_read);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      host_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      host_rdata_q <= host_rdata_d;
      err_q        <= err_d;
    end
  end

  avmm_read_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .MAX_PENDING  (MAX_PENDING),
    .ERR_DATA     (ERR_DATA)
  ) u_read_pipe (
    .clk_i    (i_clk),
    .rst_ni   (i_rstn),
    .push_i   (rd_acc),
    .oob_i    (slv_oob),
    .data_i   (rd_data),
    .rvalid_o (avs.avs_s0_readdatavalid),
    .rdata_o  (avs.avs_s0_readdata),
    .full_o   (rd_full)
  );

  assign avs.avs_s0_waitrequest = waitreq;
  assign host_rdata             = host_rdata_q;
  assign o_err                  = err_q;

endmodule

// File: doc/avmm_sdr_responder.md
Name: avmm_sdr_responder

Overview:
- Avalon-MM 16-bit slave that answers the SDRAM-side master traffic issued by the ray tracer top and its tri reader: pipelined reads, single-cycle writes, byteenable masking.
- Backed by an on-chip halfword array.
- Used as the scene/result buffer in simulation and small on-chip builds.
- Includes a host backdoor port so the ray and triangles can be preloaded and results read back.

Parameters:
- DEPTH, 4096, number of 16-bit halfwords stored.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid (1..8).
- MAX_PENDING, 4, maximum outstanding accepted reads (1..8).
- ERR_DATA, 16'hDEAD, read data returned for out-of-range addresses.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- avs_s0_read  in  1  read request
- avs_s0_write  in  1  write request
- avs_s0_address  in  32  byte address; halfword index = address[31:1]
- avs_s0_writedata  in  16  write data
- avs_s0_byteenable  in  2  bit0 = [7:0], bit1 = [15:8]
- avs_s0_readdata  out  16  read data
- avs_s0_readdatavalid  out  1  read data valid, one pulse per accepted read
- avs_s0_waitrequest  out  1  stall; a request is accepted only when this is low
- host_en  in  1  backdoor access request
- host_we  in  1  backdoor write (1) / read (0)
- host_addr  in  $clog2(DEPTH)  backdoor halfword index
- host_wdata  in  16  backdoor write data
- host_rdata  out  16  backdoor read data, valid the cycle after host_en & !host_we
- o_err  out  1  sticky protocol/range error

Behaviour:
- Reset: the asynchronous, active-low i_rstn is the only reset.
  - Clears the latency pipeline, the pending counter, o_err, readdatavalid, readdata (0) and host_rdata (0).
  - Memory contents are NOT cleared.
  - Reset mid-operation discards all in-flight reads; no readdatavalid appears after reset release for them.
- Accept conditions:
  - Read accepted on a rising edge with avs_s0_read & !avs_s0_waitrequest.
  - Write accepted with avs_s0_write & !avs_s0_waitrequest.
- Waitrequest is combinational: avs_s0_waitrequest = host_en | (pending == MAX_PENDING).
  - The host port has priority.
  - A retire in the same cycle does not lower waitrequest.
- Reads:
  - Accepted read at edge N yields readdatavalid high for exactly the cycle following edge N+READ_LATENCY-1, with data sampled from memory at edge N.
  - Back-to-back reads stream one per cycle while pending < MAX_PENDING.
  - Data are returned in acceptance order.
  - The pending counter adds the accept and subtracts the retire in the same cycle (net 0 when both occur).
- Writes:
  - Memory updated at the accept edge, per byteenable lane.
  - byteenable 2'b00 is a no-op.
  - A read accepted the cycle after a write to the same address returns the new data.
- Range:
  - Halfword index >= DEPTH: reads return ERR_DATA with normal latency; writes are dropped.
  - Either case sets o_err.
- Simultaneous read & write on the slave port is a protocol error.
  - The read is serviced, the write is dropped, o_err is set.
- Host port:
  - Write updates all 16 bits at the edge.
  - Read returns the registered value next cycle.
  - Host and slave never access memory in the same cycle, because waitrequest blocks the slave.
- o_err is sticky until reset.

Optional Feature:
- Macro: AVS_STALL_INJECT_EN.
- When defined:
  - A 4-bit LFSR (seed 4'b1001, advanced every cycle) additionally asserts waitrequest whenever LFSR[1:0] == 2'b00.
  - This exercises the master's stall handling.
  - Latency and ordering of already-accepted reads are unaffected.
- When undefined: waitrequest follows only the host/pending rule above. No LFSR logic is present.

Decomposition:
- Shared package avmm_pkg:
  - AVMM_DATA_W = 16, AVMM_ADDR_W = 32, AVMM_BE_W = 2.
  - ERR_DATA default.
  - A typedef for the read-pipeline entry {valid, oob, data}.
- One sub-module: avmm_read_pipe.
  - Fixed-latency shift register of pipeline entries with the pending counter.
  - Produces readdatavalid/readdata and the full flag.

Test Plan:
- Reset, preload, streaming read:
  - Stimulus: reset; host writes 0x1111/0x2222/0x3333 at idx 0..2; slave reads byte addresses 0, 2, 4 back-to-back.
  - Response: readdatavalid pulses at edges 2, 3, 4 after the first accept, data 0x1111, 0x2222, 0x3333; waitrequest stays low.
- Byteenable write then read:
  - Stimulus: write 0xABCD at addr 8 with be = 2'b01 over a stored 0x5566, then read addr 8 the next cycle.
  - Response: readdata = 0x55CD.
- Backpressure:
  - Stimulus: MAX_PENDING = 4, READ_LATENCY = 8; hold read high for 10 cycles.
  - Response: exactly 4 accepts, then waitrequest = 1 until the first retire; all 10 reads return in order.
- Range and protocol errors:
  - Stimulus: read at byte addr 2*DEPTH; separately, assert read and write together.
  - Response: first case returns 0xDEAD; second case leaves the write target unchanged; o_err = 1 and stays high.
- Host priority and reset mid-flight:
  - Stimulus: host_en during a slave read.
  - Response: waitrequest = 1 and the slave request is not accepted.
  - Stimulus: drop i_rstn with 3 reads pending.
  - Response: readdatavalid = 0 immediately; no pulses after release; memory preserved.
- With AVS_STALL_INJECT_EN defined:
  - Stimulus: 64 reads.
  - Response: waitrequest follows the LFSR pattern; all 64 data return correct and in order.
